maclaurin_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one ln() Maclaurin series unit among N requesters.
- Accepts x operands from requesters with a valid/ready handshake.
- Drives the unit's start/x inputs and tracks its {done,error} status until completion, then returns the ln result and error flags to the granted requester with a valid/ready handshake.
- Sits between the unit and the software/QSYS-facing register ports.

---
 rtl/maclaurin_arbiter_if.sv | 33 +++
 rtl/maclaurin_arbiter.sv | 137 +++++++++++++
 tb/tb_maclaurin_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/maclaurin_arbiter_if.sv
// Requester, response and ln-unit signals shared by the arbiter and its environment.
// The arbiter takes the slave side; the requesters and the unit together take the master side.
interface maclaurin_arbiter_if #(
    parameter int N  = 4,
    parameter int GW = 2
);
    logic [N-1:0]    req_valid;
    logic [32*N-1:0] req_x;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [31:0]     rsp_ln;
    logic            rsp_error;
    logic            rsp_timeout;
    logic [31:0]     mb_x;
    logic            mb_start;
    logic [31:0]     mb_ln;
    logic [1:0]      mb_status;
    logic            busy;
    logic [GW-1:0]   grant_id;

    modport slave (
        input  req_valid, req_x, rsp_ready, mb_ln, mb_status,
        output req_ready, rsp_valid, rsp_ln, rsp_error, rsp_timeout,
               mb_x, mb_start, busy, grant_id
    );

    modport master (
        output req_valid, req_x, rsp_ready, mb_ln, mb_status,
        input  req_ready, rsp_valid, rsp_ln, rsp_error, rsp_timeout,
               mb_x, mb_start, busy, grant_id
    );
endinterface

// File: rtl/maclaurin_arbiter.sv
// Round-robin arbiter/sequencer sharing one ln() Maclaurin unit among N requesters.
// Grants one operand, starts the unit, watches {done,error}, and returns the result.
module maclaurin_arbiter #(
    parameter int N       = 4,
    parameter int GW      = 2,
    parameter int TIMEOUT = 63
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset_n,
    maclaurin_arbiter_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND} state_t;

    localparam logic [7:0]   TMO = 8'(TIMEOUT);
    localparam logic [GW:0]  NN  = (GW+1)'(N);
    localparam logic [N-1:0] ONE = N'(1);

    state_t        state_q;
    logic [GW-1:0] rr_ptr_q, grant_q, gnt_idx, rr_next;
    logic [7:0]    cnt_q, cnt_inc;
    logic [31:0]   mb_x_q, rsp_ln_q;
    logic          mb_start_q, busy_q, rsp_error_q, rsp_timeout_q;
    logic [N-1:0]  rsp_valid_q;
    logic          gnt_found, grant_fire, cnt_expired;
    logic [GW:0]   arb_sum;

    // First valid requester at or after rr_ptr, wrapping at N-1.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        arb_sum   = '0;
        for (int k = 0; k < N; k++) begin
            arb_sum = {1'b0, rr_ptr_q} + (GW+1)'(k);
            if (arb_sum >= NN) arb_sum = arb_sum - NN;
            if (!gnt_found && bus.req_valid[arb_sum[GW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = arb_sum[GW-1:0];
            end
        end
    end

    // req_ready is decoded combinationally so the accept lands in the same
    // cycle the requester sees it; it is forced low while reset is asserted.
    assign grant_fire  = (state_q == IDLE) && gnt_found && bus.mb_status[1] && reset_reset_n;
    assign cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign cnt_expired = (cnt_inc >= TMO);
    assign rr_next     = (grant_q == GW'(N-1)) ? '0 : grant_q + GW'(1);

    assign bus.req_ready   = grant_fire ? (ONE << gnt_idx) : '0;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_ln      = rsp_ln_q;
    assign bus.rsp_error   = rsp_error_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.mb_x        = mb_x_q;
    assign bus.mb_start    = mb_start_q;
    assign bus.busy        = busy_q;
    assign bus.grant_id    = grant_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_q       <= '0;
            cnt_q         <= '0;
            mb_x_q        <= '0;
            mb_start_q    <= 1'b0;
            busy_q        <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_ln_q      <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            mb_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_fire) begin
                        mb_x_q     <= bus.req_x[32*gnt_idx +: 32];
                        grant_q    <= gnt_idx;
                        mb_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!bus.mb_status[1]) begin
                        cnt_q   <= '0;
                        state_q <= WAIT_DONE;
                    end else if (cnt_expired) begin
                        cnt_q         <= cnt_inc;
                        rsp_ln_q      <= '0;
                        rsp_error_q   <= 1'b0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= ONE << grant_q;
                        state_q       <= RESPOND;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                WAIT_DONE: begin
                    if (bus.mb_status[1]) begin
                        rsp_ln_q      <= bus.mb_ln;
                        rsp_error_q   <= bus.mb_status[0];
                        rsp_timeout_q <= 1'b0;
                        rsp_valid_q   <= ONE << grant_q;
                        state_q       <= RESPOND;
                    end else if (cnt_expired) begin
                        cnt_q         <= cnt_inc;
                        rsp_ln_q      <= '0;
                        rsp_error_q   <= 1'b0;
                        rsp_timeout_q <= 1'b1;
                        rsp_valid_q   <= ONE << grant_q;
                        state_q       <= RESPOND;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                RESPOND: begin
                    // Only the granted requester's ready can retire the response.
                    if (bus.rsp_ready[grant_q]) begin
                        rsp_valid_q <= '0;
                        rr_ptr_q    <= rr_next;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_maclaurin_arbiter.sv
// Scoreboard bench for maclaurin_arbiter with a behavioural ln-unit model.
// Stimulus pushes expected grants/responses; a negedge monitor pops and compares.
module tb_maclaurin_arbiter;
    typedef struct { int id; logic [31:0] x; } gexp_t;
    typedef struct { int id; logic [31:0] ln; logic err; logic to; int lat; } rexp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    maclaurin_arbiter_if #(.N(4), .GW(2)) bus ();

    maclaurin_arbiter #(.N(4), .GW(2), .TIMEOUT(63)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    gexp_t exp_g[$];
    rexp_t exp_r[$];

    // ln-unit model: done drops the cycle after start, stays low unit_lat cycles.
    int          unit_lat  = 4;
    logic        unit_err  = 1'b0;
    logic [31:0] unit_xor  = 32'h0;
    logic        unit_hang = 1'b0;
    logic        u_done = 1'b1;
    logic        u_err  = 1'b0;
    logic [31:0] u_ln   = 32'h0;
    logic [31:0] u_x    = 32'h0;
    int          u_bcnt = 0;

    always @(posedge clk) begin
        if (bus.mb_start && !unit_hang) begin
            u_done <= 1'b0;
            u_err  <= 1'b0;
            u_bcnt <= unit_lat - 1;
            u_x    <= bus.mb_x;
        end else if (!u_done) begin
            if (u_bcnt == 0) begin
                u_done <= 1'b1;
                u_err  <= unit_err;
                u_ln   <= u_x ^ unit_xor;
            end else begin
                u_bcnt <= u_bcnt - 1;
            end
        end
    end
    assign bus.mb_status = {u_done, u_err};
    assign bus.mb_ln     = u_ln;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    int          pend_id = 0;
    logic [31:0] pend_x = 32'h0;
    logic        pend_chk = 1'b0;
    int          grant_cyc = 0, start_cyc = 0, rsp_cyc = 0;
    logic        rsp_seen = 1'b0;

    always @(negedge clk) begin
        gexp_t g;
        rexp_t e;
        if (rst_n) begin
            if (bus.req_ready != 4'b0) begin
                checks++;
                if (exp_g.size() == 0) begin
                    errors++;
                    $display("FAIL grant: unexpected req_ready=%b, expected none", bus.req_ready);
                end else begin
                    g = exp_g.pop_front();
                    if (bus.req_ready != (4'b0001 << g.id)) begin
                        errors++;
                        $display("FAIL grant: req_ready=%b, expected id %0d", bus.req_ready, g.id);
                    end
                    pend_id = g.id; pend_x = g.x; grant_cyc = cyc; pend_chk = 1'b1;
                end
            end
            if (bus.mb_start) begin
                checks++;
                if (!pend_chk) begin
                    errors++;
                    $display("FAIL start: mb_start without a preceding grant");
                end else if (bus.mb_x != pend_x || bus.grant_id != 2'(pend_id) || cyc != grant_cyc + 1) begin
                    errors++;
                    $display("FAIL start: mb_x=%h grant_id=%0d delay=%0d, expected mb_x=%h grant_id=%0d delay=1",
                             bus.mb_x, bus.grant_id, cyc - grant_cyc, pend_x, pend_id);
                end
                pend_chk = 1'b0; start_cyc = cyc; rsp_seen = 1'b0;
            end
            if (bus.rsp_valid != 4'b0 && !rsp_seen) begin
                rsp_seen = 1'b1; rsp_cyc = cyc;
            end
            if ((bus.rsp_valid & bus.rsp_ready) != 4'b0) begin
                checks++;
                if (exp_r.size() == 0) begin
                    errors++;
                    $display("FAIL rsp: unexpected response valid=%b, expected none", bus.rsp_valid);
                end else begin
                    e = exp_r.pop_front();
                    if (bus.rsp_valid != (4'b0001 << e.id) || bus.rsp_ln != e.ln ||
                        bus.rsp_error != e.err || bus.rsp_timeout != e.to ||
                        (e.lat >= 0 && rsp_cyc - start_cyc != e.lat)) begin
                        errors++;
                        $display("FAIL rsp: valid=%b ln=%h err=%b to=%b lat=%0d, expected id %0d ln=%h err=%b to=%b lat=%0d",
                                 bus.rsp_valid, bus.rsp_ln, bus.rsp_error, bus.rsp_timeout, rsp_cyc - start_cyc,
                                 e.id, e.ln, e.err, e.to, e.lat);
                    end
                end
                rsp_seen = 1'b0;
            end
        end
    end

    // One clock; requesters drop valid after their accept.
    task automatic tick();
        logic [3:0] hs;
        @(negedge clk);
        hs = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~hs;
    endtask

    task automatic issue(input int id, input logic [31:0] x);
        bus.req_x[32*id +: 32] = x;
        bus.req_valid[id] = 1'b1;
        exp_g.push_back('{id, x});
    endtask

    task automatic push_rsp(input int id, input logic [31:0] ln, input logic err, input logic to, input int lat);
        exp_r.push_back('{id, ln, err, to, lat});
    endtask

    task automatic drain(input int budget, input string tag);
        int n = 0;
        while ((exp_g.size() != 0 || exp_r.size() != 0 || bus.busy) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: drain timed out with %0d grants, %0d responses outstanding, expected 0",
                     tag, exp_g.size(), exp_r.size());
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (bus.req_ready != 0 || bus.rsp_valid != 0 || bus.rsp_ln != 0 || bus.rsp_error ||
            bus.rsp_timeout || bus.mb_x != 0 || bus.mb_start || bus.busy || bus.grant_id != 0) begin
            errors++;
            $display("FAIL %s: rr=%b rv=%b ln=%h e=%b t=%b x=%h st=%b busy=%b gid=%0d, expected all 0",
                     tag, bus.req_ready, bus.rsp_valid, bus.rsp_ln, bus.rsp_error, bus.rsp_timeout,
                     bus.mb_x, bus.mb_start, bus.busy, bus.grant_id);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        bus.req_valid = 4'b0;
        bus.req_x     = '0;
        bus.rsp_ready = 4'b0;
        repeat (2) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // Single request, 36-cycle unit
        bus.rsp_ready = 4'hF;
        unit_lat = 36; unit_xor = 32'h1234_5778; unit_err = 1'b0;
        issue(0, 32'h0000_0100);
        push_rsp(0, 32'h1234_5678, 1'b0, 1'b0, 38);
        drain(200, "single");

        // All four from reset, then 0 re-requests behind 1..3
        do_reset();
        unit_lat = 5; unit_xor = 32'hFFFF_FFFF;
        issue(0, 32'h1111_0000);
        issue(1, 32'h2222_0001);
        issue(2, 32'h3333_0002);
        issue(3, 32'h4444_0003);
        n = 0;
        while (bus.req_valid[0] && n < 20) begin tick(); n++; end
        issue(0, 32'h5555_0004);
        push_rsp(0, 32'hEEEE_FFFF, 1'b0, 1'b0, -1);
        push_rsp(1, 32'hDDDD_FFFE, 1'b0, 1'b0, -1);
        push_rsp(2, 32'hCCCC_FFFD, 1'b0, 1'b0, -1);
        push_rsp(3, 32'hBBBB_FFFC, 1'b0, 1'b0, -1);
        push_rsp(0, 32'hAAAA_FFFB, 1'b0, 1'b0, -1);
        drain(400, "round_robin");

        // Unit error
        unit_lat = 10; unit_xor = 32'h0; unit_err = 1'b1;
        issue(2, 32'hCAFE_0002);
        push_rsp(2, 32'hCAFE_0002, 1'b1, 1'b0, 12);
        drain(100, "error");
        unit_err = 1'b0;

        // Unit never drops done -> timeout, then a normal transaction
        unit_hang = 1'b1;
        issue(1, 32'h0000_0BAD);
        push_rsp(1, 32'h0, 1'b0, 1'b1, 64);
        drain(300, "timeout");
        unit_hang = 1'b0; unit_lat = 3;
        issue(3, 32'h0000_0033);
        push_rsp(3, 32'h0000_0033, 1'b0, 1'b0, 5);
        drain(100, "after_timeout");

        // Backpressure on requester 2 with 3 pending
        bus.rsp_ready = 4'b1011;
        unit_lat = 8;
        issue(2, 32'h2222_ABCD);
        push_rsp(2, 32'h2222_ABCD, 1'b0, 1'b0, -1);
        repeat (2) tick();
        issue(3, 32'h3333_1234);
        push_rsp(3, 32'h3333_1234, 1'b0, 1'b0, -1);
        n = 0;
        while (!bus.rsp_valid[2] && n < 50) begin tick(); n++; end
        repeat (20) begin
            checks++;
            if (bus.rsp_valid != 4'b0100 || bus.rsp_ln != 32'h2222_ABCD || bus.req_ready != 4'b0 ||
                bus.mb_start || bus.rsp_error || bus.rsp_timeout) begin
                errors++;
                $display("FAIL backpressure: rv=%b ln=%h rr=%b st=%b, expected rv=0100 ln=2222abcd rr=0000 st=0",
                         bus.rsp_valid, bus.rsp_ln, bus.req_ready, bus.mb_start);
            end
            tick();
        end
        bus.rsp_ready = 4'hF;
        drain(100, "backpressure");

        // Async reset while in WAIT_DONE
        unit_lat = 30;
        issue(0, 32'h0BAD_F00D);
        n = 0;
        while (!bus.busy && n < 10) begin tick(); n++; end
        repeat (12) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        repeat (2) tick();
        rst_n = 1'b1;
        unit_lat = 4; unit_xor = 32'h0;
        issue(1, 32'h0101_0101);
        push_rsp(1, 32'h0101_0101, 1'b0, 1'b0, -1);
        drain(200, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
